clock_monitor: RTL and testbench
================================

# clock_monitor

Receiving-side checker for the divided clock produced by the board's clock-divider stage. It synchronises a slow, asynchronous monitored clock into the `inp_clk` domain and measures every half-period in `inp_clk` cycles. It declares lock after a run of in-tolerance measurements and flags faults: an out-of-range half-period, or a stuck clock. It sits next to the divider and drives status LEDs and a debug readout.

## Interface
- `CNT_W`, 25: width of the period counter and measurement output.
- `NOMINAL`, 8333334: expected half-period in `inp_clk` cycles.
- `TOL`, 1024: allowed absolute deviation from `NOMINAL`, inclusive.
- `LOCK_CNT`, 4: consecutive in-range measurements required for lock.
- `TIMEOUT`, 2*NOMINAL: cycles without an edge before a stuck fault is raised. Must be < 2^CNT_W.
- `inp_clk`, in, 1: system clock; everything is on its rising edge.
- `inp_rst_n`, in, 1: synchronous, active-low reset.
- `inp_mon`, in, 1: monitored clock, asynchronous to `inp_clk`.
- `out_half_period`, out, CNT_W: last published half-period measurement.
- `out_valid`, out, 1: one-cycle pulse when `out_half_period` updates.
- `out_edge`, out, 1: one-cycle pulse per detected `inp_mon` transition, either polarity.
- `out_locked`, out, 1: high while in state LOCKED.
- `out_fault`, out, 1: high while in state FAULT.

## Operation
- **Input path.** Two-flop synchroniser, then a third flop. `edge_det` = sync2 XOR sync3.
- **Counter `cnt`.**
  - Cleared to 0 on `edge_det`.
  - Otherwise increments.
  - Saturates at `TIMEOUT`.
- **Measurement.** `meas` = `cnt`+1, taken in the `edge_det` cycle. A divider toggling every H cycles yields `meas` = H.
- **In-range test.** NOMINAL-TOL ≤ `meas` ≤ NOMINAL+TOL. Compute in CNT_W+1 bits; no wrap.
- **Timeout condition.** `cnt` == TIMEOUT-1 with no `edge_det`.
- **States.** IDLE, MEASURE, LOCKED, FAULT. Reset state is IDLE, with `good_cnt` = 0.
  - **IDLE**
    - `edge_det` → MEASURE. Nothing is published, because the interval since reset is meaningless.
    - Timeout → FAULT.
  - **MEASURE**
    - `edge_det` → publish `meas`.
    - If in range: `good_cnt`++. Reaching `LOCK_CNT` → LOCKED.
    - If out of range: `good_cnt` = 0 and stay in MEASURE.
    - Timeout → FAULT.
  - **LOCKED**
    - `edge_det` → publish `meas`.
    - Out of range → FAULT.
    - Timeout → FAULT.
  - **FAULT**
    - `edge_det` → MEASURE with `good_cnt` = 0. Nothing is published (re-sync).
    - `cnt` holds at `TIMEOUT`.
- **Simultaneous events.** `edge_det` always takes priority over timeout in the same cycle.
- **Reset mid-operation.** Returns to IDLE and clears the counter, synchroniser flops and `good_cnt`.

## Timing
- All outputs are registered. Reset value of every output is 0, applied on the first `inp_clk` edge with `inp_rst_n` low.
- A transition on `inp_mon` that is set up before clock k gives `out_edge` high after clock k+3.
- `out_valid`, `out_half_period`, `out_locked` and `out_fault` update on that same clock, k+3.
- `out_half_period` holds its value between `out_valid` pulses, including while in FAULT.
- Stuck detection: `out_fault` rises exactly TIMEOUT cycles after the last `edge_det` cycle.

## Structure
- **Package `clock_monitor_pkg`:**
  - state enum `mon_state_t` (IDLE, MEASURE, LOCKED, FAULT);
  - default constants `NOMINAL_HALF` = 8333334, `DEF_TOL` = 1024, `DEF_LOCK_CNT` = 4.
- **Sub-module `sync_edge_detect`:** three-flop synchroniser plus XOR. Ports: clock, reset, async in, `edge_det` out.
- **Top level:** counter, FSM, `good_cnt` and output registers.

## Test plan
All scenarios use scaled parameters: CNT_W=8, NOMINAL=10, TOL=1, LOCK_CNT=4, TIMEOUT=20.
- **Lock.** Release reset, toggle `inp_mon` every 10 cycles → no `out_valid` on the first edge. Later pulses carry `out_half_period`=10; `out_locked`=1 on the 4th; `out_fault`=0 throughout.
- **Tolerance.** Half-periods 9, 11, 9, 11 → all accepted, lock achieved. A single 8 in MEASURE → published as 8, `good_cnt` reset, lock delayed by 4 further good edges.
- **Glitch while locked.** One half-period of 13 → `out_valid` with 13; in the same cycle `out_locked`=0 and `out_fault`=1. The next edge is unpublished. Relock after 4 further 10-cycle measurements.
- **Stuck clock.** Hold `inp_mon` after lock → `out_fault`=1 exactly 20 cycles after the last `out_edge`. `out_half_period` stays 10.
- **Reset mid-lock.** Pull `inp_rst_n` low for 1 cycle → all outputs 0 on the next clock. The first subsequent edge gives `out_edge` only, with no `out_valid`.

Source files
------------

// File: rtl/clock_monitor_pkg.sv
// Shared types and default constants for the divided-clock monitor.
package clock_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_t;

  localparam int NOMINAL_HALF = 8333334;
  localparam int DEF_TOL      = 1024;
  localparam int DEF_LOCK_CNT = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings the asynchronous monitored clock into the local domain and emits a
// registered one-cycle pulse per transition of either polarity.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_det
);

  // [0] and [1] form the metastability pair, [2] holds the previous level
  logic [2:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      edge_det  <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], async_in};
      edge_det  <= sync_pipe[1] ^ sync_pipe[2];
    end
  end

endmodule

// File: rtl/clock_monitor.sv
// Measures every half-period of the monitored clock, declares lock after a run
// of in-tolerance measurements and flags out-of-range or stuck clocks.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int CNT_W    = 25,
  parameter int NOMINAL  = NOMINAL_HALF,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int TIMEOUT  = 2 * NOMINAL
) (
  input  logic             inp_clk,
  input  logic             inp_rst_n,
  input  logic             inp_mon,
  output logic [CNT_W-1:0] out_half_period,
  output logic             out_valid,
  output logic             out_edge,
  output logic             out_locked,
  output logic             out_fault
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  // Window bounds carry one extra bit so NOMINAL+TOL never wraps
  localparam logic [CNT_W:0]    LO_V   = (CNT_W+1)'((NOMINAL > TOL) ? NOMINAL - TOL : 0);
  localparam logic [CNT_W:0]    HI_V   = (CNT_W+1)'(NOMINAL + TOL);
  localparam logic [CNT_W:0]    ONE_W  = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0]  TO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  TO_M1  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_1  = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_V = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_1 = GOOD_W'(1);

  logic              edge_det;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    meas;
  logic              in_range;
  logic              timeout;
  mon_state_t        state, state_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic              publish;

  sync_edge_detect u_sync (
    .clk      (inp_clk),
    .rst_n    (inp_rst_n),
    .async_in (inp_mon),
    .edge_det (edge_det)
  );

  // Counter value in the edge cycle is H-1 for a half-period of H cycles
  assign meas     = {1'b0, cnt} + ONE_W;
  assign in_range = (meas >= LO_V) && (meas <= HI_V);
  assign timeout  = !edge_det && (cnt == TO_M1);

  always_ff @(posedge inp_clk) begin
    if (!inp_rst_n)         cnt <= '0;
    else if (edge_det)      cnt <= '0;
    else if (cnt != TO_V)   cnt <= cnt + CNT_1;
  end

  always_ff @(posedge inp_clk) begin
    if (!inp_rst_n) begin
      state    <= IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // Edge handling is tested before timeout so an edge always wins a tie
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det)     state_nxt = MEASURE;
        else if (timeout) state_nxt = FAULT;
      end
      MEASURE: begin
        if (edge_det) begin
          publish = 1'b1;
          if (!in_range) begin
            good_nxt = '0;
          end else if (good_cnt + GOOD_1 == LOCK_V) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
          end else begin
            good_nxt = good_cnt + GOOD_1;
          end
        end else if (timeout) begin
          state_nxt = FAULT;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          publish = 1'b1;
          if (!in_range) state_nxt = FAULT;
        end else if (timeout) begin
          state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (edge_det) begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags follow the next state so they move with the valid pulse
  always_ff @(posedge inp_clk) begin
    if (!inp_rst_n) begin
      out_half_period <= '0;
      out_valid       <= 1'b0;
      out_edge        <= 1'b0;
      out_locked      <= 1'b0;
      out_fault       <= 1'b0;
    end else begin
      out_valid  <= publish;
      out_edge   <= edge_det;
      out_locked <= (state_nxt == LOCKED);
      out_fault  <= (state_nxt == FAULT);
      if (publish) out_half_period <= meas[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: directed vector table, corner sequences and a
// randomized run checked every cycle against a timestamp-based model.
module tb_clock_monitor;

  localparam int CNT_W    = 8;
  localparam int NOMINAL  = 10;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 20;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             mon   = 1'b0;
  logic [CNT_W-1:0] half_period;
  logic             valid, mon_edge, locked, fault;

  clock_monitor #(
    .CNT_W(CNT_W), .NOMINAL(NOMINAL), .TOL(TOL),
    .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .inp_clk         (clk),
    .inp_rst_n       (rst_n),
    .inp_mon         (mon),
    .out_half_period (half_period),
    .out_valid       (valid),
    .out_edge        (mon_edge),
    .out_locked      (locked),
    .out_fault       (fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: tracks the time of the last edge (or reset) and derives each
  // measurement as a timestamp difference.
  localparam int M_IDLE = 0, M_MEAS = 1, M_LOCK = 2, M_FAULT = 3;
  int cyc = 0, last = 0, good = 0, mode = M_IDLE, e_half = 0;
  bit seen = 0;
  bit pend[int];
  bit e_edge = 0, e_valid = 0, e_locked = 0, e_fault = 0;

  typedef struct { int rst, gap, valid, half, locked, fault; } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ok_range(input int m);
    return (m >= NOMINAL - TOL) && (m <= NOMINAL + TOL);
  endfunction

  task automatic model_step();
    int  diff;
    bit  ev;
    cyc++;
    e_edge  = 0;
    e_valid = 0;
    if (!rst_n) begin
      seen = 0; pend.delete(); last = cyc; mode = M_IDLE; good = 0;
      e_half = 0; e_locked = 0; e_fault = 0;
      return;
    end
    ev = pend.exists(cyc);
    if (ev) pend.delete(cyc);
    // a level change seen at this edge surfaces on the outputs three clocks later
    if (mon != seen) begin pend[cyc + 3] = 1; seen = mon; end
    diff = cyc - last;
    if (ev) begin
      e_edge = 1;
      last   = cyc;
      case (mode)
        M_IDLE:  mode = M_MEAS;
        M_FAULT: begin mode = M_MEAS; good = 0; end
        M_MEAS: begin
          e_valid = 1; e_half = diff;
          if (ok_range(diff)) begin
            good++;
            if (good == LOCK_CNT) begin mode = M_LOCK; good = 0; end
          end else good = 0;
        end
        default: begin
          e_valid = 1; e_half = diff;
          if (!ok_range(diff)) mode = M_FAULT;
        end
      endcase
    end else if (diff == TIMEOUT && mode != M_FAULT) begin
      mode = M_FAULT;
    end
    e_locked = (mode == M_LOCK);
    e_fault  = (mode == M_FAULT);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model edge",   int'(mon_edge),    int'(e_edge));
    chk("model valid",  int'(valid),       int'(e_valid));
    chk("model half",   int'(half_period), e_half);
    chk("model locked", int'(locked),      int'(e_locked));
    chk("model fault",  int'(fault),       int'(e_fault));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mon   = 1'b0;
    tick();
    chk("reset edge",   int'(mon_edge),    0);
    chk("reset valid",  int'(valid),       0);
    chk("reset half",   int'(half_period), 0);
    chk("reset locked", int'(locked),      0);
    chk("reset fault",  int'(fault),       0);
    rst_n = 1'b1;
  endtask

  // gap = clocks between this toggle and the previous one (or the reset)
  task automatic run_vec(input vec_t v);
    if (v.rst != 0) do_reset();
    repeat (v.gap - 4) tick();
    mon = ~mon;
    repeat (4) tick();
    chk("tbl edge",   int'(mon_edge),    1);
    chk("tbl valid",  int'(valid),       v.valid);
    chk("tbl half",   int'(half_period), v.half);
    chk("tbl locked", int'(locked),      v.locked);
    chk("tbl fault",  int'(fault),       v.fault);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   r, g;

    // lock
    tbl.push_back('{1, 5, 0, 0, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 1, 0});
    // glitch while locked, unpublished re-sync, relock; window edges stay locked
    tbl.push_back('{0, 13, 1, 13, 0, 1});
    tbl.push_back('{0, 10, 0, 13, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 1, 0});
    tbl.push_back('{0, 11, 1, 11, 1, 0});
    tbl.push_back('{0, 9, 1, 9, 1, 0});
    // tolerance
    tbl.push_back('{1, 5, 0, 0, 0, 0});
    tbl.push_back('{0, 9, 1, 9, 0, 0});
    tbl.push_back('{0, 11, 1, 11, 0, 0});
    tbl.push_back('{0, 9, 1, 9, 0, 0});
    tbl.push_back('{0, 11, 1, 11, 1, 0});
    // single 8 in MEASURE restarts the run; 12 while locked faults
    tbl.push_back('{1, 5, 0, 0, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 8, 1, 8, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 1, 0});
    tbl.push_back('{0, 12, 1, 12, 0, 1});
    tbl.push_back('{0, 10, 0, 12, 0, 0});
    // edge landing on the timeout cycle wins and is published
    tbl.push_back('{1, 5, 0, 0, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});
    tbl.push_back('{0, 20, 1, 20, 0, 0});
    tbl.push_back('{0, 10, 1, 10, 0, 0});

    do_reset();
    foreach (tbl[i]) run_vec(tbl[i]);

    // stuck clock after lock
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    repeat (19) tick();
    chk("stuck early", int'(fault), 0);
    tick();
    chk("stuck fault",  int'(fault),       1);
    chk("stuck locked", int'(locked),      0);
    chk("stuck half",   int'(half_period), 10);
    v = '{0, 4, 0, 10, 0, 0};
    run_vec(v);

    // no edge at all after reset
    do_reset();
    repeat (19) tick();
    chk("idle early", int'(fault), 0);
    tick();
    chk("idle fault", int'(fault), 1);

    // reset while locked
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);
    do_reset();
    v = '{0, 5, 0, 0, 0, 0};
    run_vec(v);

    // randomized half-periods, stalls and resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst_n = 1'b0;
        mon   = 1'($urandom_range(0, 1));
        repeat (int'($urandom_range(1, 2))) tick();
        rst_n = 1'b1;
      end else begin
        if (r < 75)      g = int'($urandom_range(9, 11));
        else if (r < 95) g = int'($urandom_range(1, 22));
        else             g = int'($urandom_range(21, 30));
        mon = ~mon;
        repeat (g) tick();
      end
    end
    repeat (30) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
